// File: rtl/rvfi_regfile_check.sv
// rvfi_regfile_check: passive RVFI monitor keeping shadow copies of a set of
// architectural registers, checking reads against them, enforcing x0 rules and
// optionally checking rvfi_order continuity.
// Optional feature macro: RISCV_FORMAL_REGCHK_ORDER_EN (rvfi_order gap check).
module rvfi_regfile_check #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NRET      = 1,
   parameter int unsigned NTRACK    = 4,
   parameter int unsigned ORDER_W   = 64,
   parameter bit          ZERO_INIT = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NTRACK*5-1:0]     track_idx,
   input  logic [NRET-1:0]         rvfi_valid,
   input  logic [NRET*ORDER_W-1:0] rvfi_order,
   input  logic [NRET*5-1:0]       rvfi_rs1_addr,
   input  logic [NRET*5-1:0]       rvfi_rs2_addr,
   input  logic [NRET*5-1:0]       rvfi_rd_addr,
   input  logic [NRET*XLEN-1:0]    rvfi_rs1_rdata,
   input  logic [NRET*XLEN-1:0]    rvfi_rs2_rdata,
   input  logic [NRET*XLEN-1:0]    rvfi_rd_wdata,
   output logic                    err_valid,
   output logic [3:0]              err_code,
   output logic [3:0]              err_sticky,
   output logic [ORDER_W-1:0]      err_order
);

   localparam int unsigned AW = 5;

   logic [AW-1:0]      trk        [NTRACK];
   logic [XLEN-1:0]    shadow     [NTRACK];
   logic [NTRACK-1:0]  sval;
   logic [XLEN-1:0]    shadow_nxt [NTRACK];
   logic [NTRACK-1:0]  sval_nxt;
   logic [3:0]         code_nxt;
   logic               fail_found_c;
   logic [ORDER_W-1:0] fail_order_nxt;

   logic [3:0]         ch_err;
   logic [AW-1:0]      rs1a, rs2a, rda;
   logic [XLEN-1:0]    rs1d, rs2d, rdd;
   logic [ORDER_W-1:0] ord;

`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
   logic [ORDER_W-1:0] exp_ord, exp_ord_nxt;
   logic               oval, oval_nxt;
`endif

   // Sequential walk over the retirement channels with write forwarding.
   always_comb begin
      shadow_nxt     = shadow;
      sval_nxt       = sval;
      code_nxt       = '0;
      fail_found_c   = 1'b0;
      fail_order_nxt = '0;
      ch_err         = '0;
      rs1a           = '0;
      rs2a           = '0;
      rda            = '0;
      rs1d           = '0;
      rs2d           = '0;
      rdd            = '0;
      ord            = '0;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
      exp_ord_nxt    = exp_ord;
      oval_nxt       = oval;
`endif
      for (int unsigned c = 0; c < NRET; c++) begin
         if (rvfi_valid[c]) begin
            ch_err = '0;
            rs1a   = rvfi_rs1_addr[c*AW +: AW];
            rs2a   = rvfi_rs2_addr[c*AW +: AW];
            rda    = rvfi_rd_addr[c*AW +: AW];
            rs1d   = rvfi_rs1_rdata[c*XLEN +: XLEN];
            rs2d   = rvfi_rs2_rdata[c*XLEN +: XLEN];
            rdd    = rvfi_rd_wdata[c*XLEN +: XLEN];
            ord    = rvfi_order[c*ORDER_W +: ORDER_W];

            for (int unsigned k = 0; k < NTRACK; k++) begin
               if (sval_nxt[k] && (rs1a == trk[k]) && (rs1d != shadow_nxt[k]))
                  ch_err[0] = 1'b1;
               if (sval_nxt[k] && (rs2a == trk[k]) && (rs2d != shadow_nxt[k]))
                  ch_err[1] = 1'b1;
            end

            if (((rs1a == '0) && (rs1d != '0)) ||
                ((rs2a == '0) && (rs2d != '0)) ||
                ((rda  == '0) && (rdd  != '0)))
               ch_err[2] = 1'b1;

`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
            // Resynchronise on every retirement so one gap raises one error.
            if (oval_nxt && (ord != exp_ord_nxt))
               ch_err[3] = 1'b1;
            exp_ord_nxt = ord + 1'b1;
            oval_nxt    = 1'b1;
`endif

            for (int unsigned k = 0; k < NTRACK; k++) begin
               if ((rda != '0) && (rda == trk[k])) begin
                  shadow_nxt[k] = rdd;
                  sval_nxt[k]   = 1'b1;
               end
            end

            code_nxt = code_nxt | ch_err;
            if ((ch_err != '0) && !fail_found_c) begin
               fail_found_c   = 1'b1;
               fail_order_nxt = ord;
            end
         end
      end
   end

   // Shadow state, tracked indices and registered error reporting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < NTRACK; k++) begin
            trk[k]    <= track_idx[k*AW +: AW];
            shadow[k] <= '0;
         end
         sval       <= {NTRACK{ZERO_INIT}};
         err_valid  <= 1'b0;
         err_code   <= '0;
         err_sticky <= '0;
         err_order  <= '0;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
         exp_ord    <= '0;
         oval       <= 1'b0;
`endif
      end else begin
         shadow     <= shadow_nxt;
         sval       <= sval_nxt;
         err_valid  <= |code_nxt;
         err_code   <= code_nxt;
         err_sticky <= err_sticky | code_nxt;
         // An empty sticky means no failing retirement has been recorded yet.
         if ((err_sticky == '0) && fail_found_c)
            err_order <= fail_order_nxt;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
         exp_ord    <= exp_ord_nxt;
         oval       <= oval_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rvfi_regfile_check.sv
// Testbench for rvfi_regfile_check: directed steps plus randomized retirements
// checked against an architectural register-file reference model.
module tb_rvfi_regfile_check;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NRET   = 2;
   localparam int unsigned NTRACK = 4;
   localparam int unsigned OW     = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NTRACK*5-1:0]  track_idx;
   logic [NRET-1:0]      rvfi_valid;
   logic [NRET*OW-1:0]   rvfi_order;
   logic [NRET*5-1:0]    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
   logic [NRET*XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
   logic                 err_valid;
   logic [3:0]           err_code, err_sticky;
   logic [OW-1:0]        err_order;

   rvfi_regfile_check #(
      .XLEN(XLEN), .NRET(NRET), .NTRACK(NTRACK), .ORDER_W(OW), .ZERO_INIT(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .track_idx(track_idx),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
      .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
      .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
      .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
      .err_valid(err_valid), .err_code(err_code),
      .err_sticky(err_sticky), .err_order(err_order)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Per-channel stimulus for the next step.
   bit            ch_v   [NRET];
   logic [OW-1:0] ch_ord [NRET];
   logic [4:0]    ch_rs1 [NRET], ch_rs2 [NRET], ch_rd [NRET];
   logic [31:0]   ch_rs1d[NRET], ch_rs2d[NRET], ch_wd [NRET];

   // Reference model: architectural values of tracked registers.
   logic [31:0]   arch  [32];
   bit            known [32];
   int            m_trk [NTRACK];
   logic [3:0]    m_sticky;
   logic [OW-1:0] m_eorder, m_exp;
   bit            m_oval;
   logic [3:0]    exp_code;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic bit is_tracked(input int r);
      for (int k = 0; k < NTRACK; k++) if (m_trk[k] == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset(input int t0, input int t1, input int t2, input int t3);
      m_trk[0] = t0; m_trk[1] = t1; m_trk[2] = t2; m_trk[3] = t3;
      for (int r = 0; r < 32; r++) begin arch[r] = '0; known[r] = 1'b0; end
      m_sticky = '0; m_eorder = '0; m_exp = '0; m_oval = 1'b0;
   endtask

   task automatic clr_ch();
      for (int c = 0; c < NRET; c++) begin
         ch_v[c] = 1'b0; ch_ord[c] = '0; ch_rs1[c] = '0; ch_rs2[c] = '0; ch_rd[c] = '0;
         ch_rs1d[c] = '0; ch_rs2d[c] = '0; ch_wd[c] = '0;
      end
   endtask

   task automatic set_ch(input int c, input int ord, input int rs1, input logic [31:0] rs1d,
                         input int rs2, input logic [31:0] rs2d, input int rd, input logic [31:0] wd);
      ch_v[c] = 1'b1; ch_ord[c] = OW'(ord);
      ch_rs1[c] = 5'(rs1); ch_rs1d[c] = rs1d;
      ch_rs2[c] = 5'(rs2); ch_rs2d[c] = rs2d;
      ch_rd[c]  = 5'(rd);  ch_wd[c]   = wd;
   endtask

   task automatic pack();
      for (int c = 0; c < NRET; c++) begin
         rvfi_valid[c]              = ch_v[c];
         rvfi_order[c*OW +: OW]     = ch_ord[c];
         rvfi_rs1_addr[c*5 +: 5]    = ch_rs1[c];
         rvfi_rs2_addr[c*5 +: 5]    = ch_rs2[c];
         rvfi_rd_addr[c*5 +: 5]     = ch_rd[c];
         rvfi_rs1_rdata[c*32 +: 32] = ch_rs1d[c];
         rvfi_rs2_rdata[c*32 +: 32] = ch_rs2d[c];
         rvfi_rd_wdata[c*32 +: 32]  = ch_wd[c];
      end
   endtask

   // Apply the model's rules to this cycle's retirements.
   task automatic model_cycle();
      logic [3:0]    e;
      bit            found = 1'b0;
      logic [OW-1:0] fo = '0;
      exp_code = '0;
      for (int c = 0; c < NRET; c++) begin
         if (ch_v[c]) begin
            e = '0;
            if (is_tracked(ch_rs1[c]) && known[ch_rs1[c]] && ch_rs1d[c] != arch[ch_rs1[c]]) e[0] = 1'b1;
            if (is_tracked(ch_rs2[c]) && known[ch_rs2[c]] && ch_rs2d[c] != arch[ch_rs2[c]]) e[1] = 1'b1;
            if ((ch_rs1[c] == 0 && ch_rs1d[c] != 0) || (ch_rs2[c] == 0 && ch_rs2d[c] != 0) ||
                (ch_rd[c] == 0 && ch_wd[c] != 0)) e[2] = 1'b1;
`ifdef RISCV_FORMAL_REGCHK_ORDER_EN
            if (m_oval && ch_ord[c] != m_exp) e[3] = 1'b1;
            m_exp  = ch_ord[c] + 1'b1;
            m_oval = 1'b1;
`endif
            if (ch_rd[c] != 0 && is_tracked(ch_rd[c])) begin
               arch[ch_rd[c]]  = ch_wd[c];
               known[ch_rd[c]] = 1'b1;
            end
            exp_code = exp_code | e;
            if (e != 0 && !found) begin found = 1'b1; fo = ch_ord[c]; end
         end
      end
      if (m_sticky == 0 && found) m_eorder = fo;
      m_sticky = m_sticky | exp_code;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".err_valid"},  64'(err_valid),  64'(exp_code != 0));
      chk({tag, ".err_code"},   64'(err_code),   64'(exp_code));
      chk({tag, ".err_sticky"}, 64'(err_sticky), 64'(m_sticky));
      chk({tag, ".err_order"},  64'(err_order),  64'(m_eorder));
   endtask

   // One clock: drive, predict, then sample one time unit after the edge.
   task automatic step(input string tag);
      pack();
      model_cycle();
      @(posedge clk);
      #1;
      check_outputs(tag);
      clr_ch();
   endtask

   function automatic logic [31:0] cur_val(input int c, input int a);
      logic [31:0] v;
      if (a == 0) return '0;
      v = arch[a];
      for (int j = 0; j < c; j++) if (ch_v[j] && ch_rd[j] == 5'(a)) v = ch_wd[j];
      return v;
   endfunction

   function automatic int pick_addr();
      int r = int'($urandom_range(0, 3));
      if (r == 0) return 0;
      if (r == 3) return int'($urandom_range(0, 31));
      return m_trk[$urandom_range(0, NTRACK - 1)];
   endfunction

   function automatic logic [31:0] pick_data(input int c, input int a);
      if ($urandom_range(0, 9) < 8) return cur_val(c, a);
      return $urandom;
   endfunction

   int ord_ctr;

   initial begin
      clr_ch();
      pack();
      reset     = 1'b1;
      track_idx = {5'd8, 5'd7, 5'd6, 5'd5};
      model_reset(5, 6, 7, 8);
      exp_code = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Write then read a tracked register.
      set_ch(0, 0, 0, 0, 0, 0, 5, 32'h1234);             step("wr5");
      set_ch(0, 1, 5, 32'h1234, 0, 0, 0, 0);             step("rd5_ok");
      set_ch(0, 2, 0, 0, 5, 32'h1235, 0, 0);             step("rs2_bad");
      set_ch(0, 3, 7, 32'h9, 0, 0, 0, 0);                step("clean_after");
      step("idle");
      // Same-cycle forwarding from channel 0 to channel 1.
      set_ch(0, 4, 0, 0, 0, 0, 6, 32'hAA);
      set_ch(1, 5, 6, 32'hAA, 0, 0, 0, 0);               step("fwd_ok");
      set_ch(0, 6, 0, 0, 0, 0, 6, 32'hAA);
      set_ch(1, 7, 6, 32'h00, 0, 0, 0, 0);               step("fwd_bad");
      // x0 rules.
      set_ch(0, 8, 0, 0, 0, 0, 0, 32'h1);                step("x0_wr");
      set_ch(0, 9, 0, 0, 0, 0, 0, 0);                    step("x0_rd_ok");
      // Order continuity with a gap at 13.
      set_ch(0, 10, 0, 0, 0, 0, 0, 0);                   step("ord10");
      set_ch(0, 11, 0, 0, 0, 0, 0, 0);                   step("ord11");
      set_ch(0, 13, 0, 0, 0, 0, 0, 0);                   step("ord13");
      set_ch(0, 14, 0, 0, 0, 0, 0, 0);                   step("ord14");
      // Same-cycle duplicate writes: highest channel wins.
      set_ch(0, 15, 0, 0, 0, 0, 7, 32'h11);
      set_ch(1, 16, 0, 0, 0, 0, 7, 32'h22);              step("dup_wr");
      set_ch(0, 17, 7, 32'h22, 0, 0, 0, 0);              step("dup_rd");

      // Randomized retirements.
      ord_ctr = 18;
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NRET; c++) begin
            if ($urandom_range(0, 9) < 8) begin
               int a1 = pick_addr();
               int a2 = pick_addr();
               int ad = pick_addr();
               logic [31:0] wd = (ad == 0 && $urandom_range(0, 9) < 9) ? 32'h0 : $urandom;
               if ($urandom_range(0, 19) == 0) ord_ctr += 2; else ord_ctr += 1;
               set_ch(c, ord_ctr, a1, pick_data(c, a1), a2, pick_data(c, a2), ad, wd);
            end
         end
         step("rand");
      end

      // Reset fresh, then exercise order wrap.
      @(negedge clk);
      reset = 1'b1;
      model_reset(5, 6, 7, 8);
      exp_code = '0;
      @(negedge clk);
      reset = 1'b0;
      set_ch(0, 32'hFFFF, 0, 0, 0, 0, 0, 0);             step("wrap_max");
      set_ch(0, 0, 0, 0, 0, 0, 0, 0);                    step("wrap_zero");
      set_ch(0, 1, 0, 0, 0, 0, 5, 32'h55);               step("pre_rst_wr");

      // Mid-cycle reset with a pending error.
      set_ch(0, 2, 0, 32'h5, 0, 0, 0, 0);                step("pending_err");
      #2;
      track_idx = {5'd12, 5'd11, 5'd6, 5'd5};
      reset     = 1'b1;
      model_reset(5, 6, 11, 12);
      exp_code  = '0;
      #1;
      check_outputs("async_rst");
      // Retirements while reset is high are ignored.
      set_ch(0, 3, 0, 0, 0, 0, 5, 32'h77);
      pack();
      @(posedge clk);
      #1;
      check_outputs("in_rst");
      clr_ch();
      pack();
      @(negedge clk);
      reset = 1'b0;
      set_ch(0, 50, 5, 32'hDEAD, 0, 0, 0, 0);            step("stale_rd");
      set_ch(0, 51, 0, 0, 0, 0, 11, 32'h3);              step("wr11");
      set_ch(0, 52, 11, 32'h4, 0, 0, 0, 0);              step("rd11_bad");
      set_ch(0, 53, 0, 0, 0, 0, 7, 32'h1);
      set_ch(1, 54, 7, 32'h2, 0, 0, 0, 0);               step("untracked7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
